// File: rtl/mips_cpu_run_controller_pkg.sv
// Shared types for the MIPS CPU run controller: sequencer states and the
// completion status flags reported to the harness.
package mips_tb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    WAIT_ACT,
    RUN,
    DONE
  } run_state_t;

  typedef struct packed {
    logic pass;
    logic timed_out;
    logic no_active;
  } run_status_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mips_cpu_run_controller_if.sv
// Harness-side and CPU-side signals of the run controller. The optional v0
// trace outputs exist only when RUN_CTRL_V0_TRACE_EN is defined.
interface mips_cpu_run_controller_if #(
  parameter int CNT_W  = 32,
  parameter int DATA_W = 32
);
  logic              start;
  logic [CNT_W-1:0]  timeout_cycles;
  logic [DATA_W-1:0] expected_v0;
  logic              cpu_reset;
  logic              cpu_clk_enable;
  logic              cpu_active;
  logic [DATA_W-1:0] cpu_register_v0;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timed_out;
  logic              no_active;
  logic [DATA_W-1:0] result_v0;
  logic [CNT_W-1:0]  cycle_count;
`ifdef RUN_CTRL_V0_TRACE_EN
  logic [CNT_W-1:0]  v0_changes;
  logic [CNT_W-1:0]  last_change_cycle;
`endif

  modport slave (
    input  start, timeout_cycles, expected_v0, cpu_active, cpu_register_v0,
    output cpu_reset, cpu_clk_enable, busy, done, pass, timed_out, no_active,
           result_v0, cycle_count
`ifdef RUN_CTRL_V0_TRACE_EN
    , output v0_changes, last_change_cycle
`endif
  );

  modport master (
    output start, timeout_cycles, expected_v0, cpu_active, cpu_register_v0,
    input  cpu_reset, cpu_clk_enable, busy, done, pass, timed_out, no_active,
           result_v0, cycle_count
`ifdef RUN_CTRL_V0_TRACE_EN
    , input v0_changes, last_change_cycle
`endif
  );

endinterface

// File: rtl/mips_cpu_run_controller_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/mips_cpu_run_controller.sv
// Run sequencer/checker for one mips_cpu_harvard: reset pulse, enable, wait for
// active to fall, then grade v0. Optional v0 trace: define RUN_CTRL_V0_TRACE_EN.
module mips_cpu_run_controller
  import mips_tb_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int RESET_HOLD  = 2,
  parameter int ACTIVE_WAIT = 4,
  parameter int DATA_W      = 32
) (
  input logic                    clk,
  input logic                    reset,
  mips_cpu_run_controller_if.slave bus
);
  localparam int PH_W = $clog2(max_int(RESET_HOLD, ACTIVE_WAIT) + 1);

  run_state_t        r_state;
  run_state_t        w_state_next;
  logic              r_armed;
  logic [CNT_W-1:0]  r_limit;
  logic [DATA_W-1:0] r_expected;
  logic [DATA_W-1:0] r_result_v0;
  run_status_t       r_status;

  logic              w_start_acc;
  logic              w_hold_end;
  logic              w_wait_expire;
  logic              w_limit_hit;
  logic              w_finish;
  logic [PH_W-1:0]   w_phase;
  logic [CNT_W-1:0]  w_cycle_count;
  logic [CNT_W-1:0]  w_cnt_plus1;

  // r_armed stays low until the first edge after reset release, which both
  // keeps the CPU in reset and masks a start coinciding with the release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_armed <= 1'b0;
    else        r_armed <= 1'b1;
  end

  assign w_start_acc   = bus.start && r_armed && ((r_state == IDLE) || (r_state == DONE));
  assign w_hold_end    = (r_state == HOLD) && (w_phase == PH_W'(RESET_HOLD - 1));
  assign w_wait_expire = (r_state == WAIT_ACT) && !bus.cpu_active &&
                         (w_phase == PH_W'(ACTIVE_WAIT - 1));
  assign w_cnt_plus1   = w_cycle_count + CNT_W'(1);
  assign w_limit_hit   = (r_limit != '0) && (w_cnt_plus1 == r_limit);
  assign w_finish      = (r_state == RUN) && (!bus.cpu_active || w_limit_hit);

  sat_counter #(.W(PH_W)) u_phase_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (w_state_next != r_state),
    .inc   ((r_state == HOLD) || (r_state == WAIT_ACT)),
    .count (w_phase)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (w_start_acc),
    .inc   (r_state == RUN),
    .count (w_cycle_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (w_start_acc) w_state_next = HOLD;
      HOLD:       if (w_hold_end) w_state_next = WAIT_ACT;
      WAIT_ACT: begin
        if (bus.cpu_active)     w_state_next = RUN;
        else if (w_wait_expire) w_state_next = DONE;
      end
      RUN:        if (w_finish) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_reset      = !r_armed;
    bus.cpu_clk_enable = 1'b0;
    bus.busy           = 1'b0;
    bus.done           = 1'b0;
    case (r_state)
      HOLD: begin
        bus.cpu_reset = 1'b1;
        bus.busy      = 1'b1;
      end
      WAIT_ACT, RUN: begin
        bus.cpu_clk_enable = 1'b1;
        bus.busy           = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // A finish with active still high can only be the limit, so timed_out is
  // simply the sampled active flag; a falling active wins a same-cycle limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_limit     <= '0;
      r_expected  <= '0;
      r_result_v0 <= '0;
      r_status    <= '0;
    end else if (w_start_acc) begin
      r_limit     <= bus.timeout_cycles;
      r_expected  <= bus.expected_v0;
      r_result_v0 <= '0;
      r_status    <= '0;
    end else if (w_wait_expire) begin
      r_status.no_active <= 1'b1;
    end else if (w_finish) begin
      r_result_v0        <= bus.cpu_register_v0;
      r_status.pass      <= !bus.cpu_active && (bus.cpu_register_v0 == r_expected);
      r_status.timed_out <= bus.cpu_active;
    end
  end

  assign bus.pass        = r_status.pass;
  assign bus.timed_out   = r_status.timed_out;
  assign bus.no_active   = r_status.no_active;
  assign bus.result_v0   = r_result_v0;
  assign bus.cycle_count = w_cycle_count;

`ifdef RUN_CTRL_V0_TRACE_EN
  logic [DATA_W-1:0] r_prev_v0;
  logic [CNT_W-1:0]  r_last_change;
  logic [CNT_W-1:0]  w_v0_changes;
  logic              w_v0_changed;

  assign w_v0_changed = (r_state == RUN) && (bus.cpu_register_v0 != r_prev_v0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_v0     <= '0;
      r_last_change <= '0;
    end else begin
      r_prev_v0 <= bus.cpu_register_v0;
      if (w_start_acc)       r_last_change <= '0;
      else if (w_v0_changed) r_last_change <= w_cycle_count;
    end
  end

  sat_counter #(.W(CNT_W)) u_v0_change_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (w_start_acc),
    .inc   (w_v0_changed),
    .count (w_v0_changes)
  );

  assign bus.v0_changes        = w_v0_changes;
  assign bus.last_change_cycle = r_last_change;
`endif

endmodule

// File: tb/tb_mips_cpu_run_controller.sv
// Directed bench for mips_cpu_run_controller: table of runs against a
// behavioural CPU stub, plus reset-abort and start-masking sequences.
module tb_mips_cpu_run_controller;
  localparam int CNT_W  = 32;
  localparam int DATA_W = 32;
  localparam int RH     = 2;
  localparam int AW     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mips_cpu_run_controller_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

  mips_cpu_run_controller #(
    .CNT_W(CNT_W), .RESET_HOLD(RH), .ACTIVE_WAIT(AW), .DATA_W(DATA_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] timeout;
    logic [31:0] expected;
    int          delay;    // enabled cycles before the stub raises active
    int          run_len;  // RUN cycle on which active drops (0 = never)
    logic [31:0] v0;
    bit          trace;    // v0 steps 0->1->2 at RUN cycles 3 and 6
    bit          poke;     // pulse start mid-run (must be ignored)
    bit          exp_pass;
    bit          exp_to;
    bit          exp_na;
    logic [31:0] exp_v0;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [31:0] to, input logic [31:0] ex, input int d,
                              input int len, input logic [31:0] v0, input bit tr, input bit pk,
                              input bit ep, input bit et, input bit en,
                              input logic [31:0] ev0, input logic [31:0] ec);
    vec_t v;
    v.timeout = to; v.expected = ex; v.delay = d; v.run_len = len; v.v0 = v0;
    v.trace = tr; v.poke = pk; v.exp_pass = ep; v.exp_to = et; v.exp_na = en;
    v.exp_v0 = ev0; v.exp_count = ec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic drive_cpu(input int en_cnt, input int d, input int len,
                           input logic [31:0] v0, input bit tr);
    int rc;
    bus.cpu_active = (en_cnt >= 1 + d) && ((len == 0) || (en_cnt < 1 + d + len));
    rc = en_cnt - 1 - d;
    if (tr) bus.cpu_register_v0 = (rc >= 6) ? 32'd2 : ((rc >= 3) ? 32'd1 : 32'd0);
    else    bus.cpu_register_v0 = v0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int en_cnt, holds, lat, exp_lat;
    bit poked, seen_done;
    string p;
    p = $sformatf("vec%0d", idx);
    @(negedge clk);
    bus.start = 1'b1;
    bus.timeout_cycles = v.timeout;
    bus.expected_v0 = v.expected;
    drive_cpu(0, v.delay, v.run_len, v.v0, v.trace);
    @(negedge clk);
    bus.start = 1'b0;
    bus.timeout_cycles = 32'd3;
    bus.expected_v0 = ~v.expected;
    check({p, "_start_cpu_reset"}, bus.cpu_reset, 1);
    check({p, "_start_busy"}, bus.busy, 1);
    check({p, "_start_done_clr"}, bus.done, 0);
    check({p, "_start_count_clr"}, bus.cycle_count, 0);
`ifdef RUN_CTRL_V0_TRACE_EN
    check({p, "_start_v0chg_clr"}, bus.v0_changes, 0);
`endif
    en_cnt = 0; holds = 0; lat = 0; poked = 0; seen_done = 0;
    for (int k = 1; k <= 400; k++) begin
      if (bus.done) begin
        lat = k;
        seen_done = 1;
        break;
      end
      if (bus.cpu_reset) begin
        en_cnt = 0;
        holds++;
      end else if (bus.cpu_clk_enable) begin
        en_cnt++;
      end
      drive_cpu(en_cnt, v.delay, v.run_len, v.v0, v.trace);
      if (v.poke && !poked && en_cnt == 8) begin
        bus.start = 1'b1;
        poked = 1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({p, "_done_within_budget"}, seen_done, 1);
    exp_lat = v.exp_na ? (RH + AW + 1) : (RH + v.delay + 1 + int'(v.exp_count) + 1);
    check({p, "_latency"}, lat, exp_lat);
    check({p, "_hold_cycles"}, holds, RH);
    check({p, "_pass"}, bus.pass, v.exp_pass);
    check({p, "_timed_out"}, bus.timed_out, v.exp_to);
    check({p, "_no_active"}, bus.no_active, v.exp_na);
    check({p, "_result_v0"}, bus.result_v0, v.exp_v0);
    check({p, "_cycle_count"}, bus.cycle_count, v.exp_count);
    check({p, "_busy_done"}, bus.busy, 0);
    check({p, "_clk_en_done"}, bus.cpu_clk_enable, 0);
    check({p, "_cpu_reset_done"}, bus.cpu_reset, 0);
`ifdef RUN_CTRL_V0_TRACE_EN
    if (v.trace) begin
      check({p, "_v0_changes"}, bus.v0_changes, 2);
      check({p, "_last_change"}, bus.last_change_cycle, 5);
    end
`endif
    @(negedge clk);
    check({p, "_done_held"}, bus.done, 1);
    check({p, "_count_held"}, bus.cycle_count, v.exp_count);
    $display("run %0d: to=%0d delay=%0d len=%0d -> pass=%0b to=%0b na=%0b v0=%0h cycles=%0d lat=%0d",
             idx, v.timeout, v.delay, v.run_len, bus.pass, bus.timed_out, bus.no_active,
             bus.result_v0, bus.cycle_count, lat);
  endtask

  initial begin
    int en;
    bit reached;
    bus.start = 1'b0;
    bus.timeout_cycles = '0;
    bus.expected_v0 = '0;
    bus.cpu_active = 1'b0;
    bus.cpu_register_v0 = '0;

    vecs[0]  = mk(100, 5, 1, 20, 5, 0, 0, 1, 0, 0, 5, 20);       // normal
    vecs[1]  = mk(100, 5, 1, 20, 6, 0, 0, 0, 0, 0, 6, 20);       // v0 mismatch
    vecs[2]  = mk(10, 5, 1, 0, 5, 0, 0, 0, 1, 0, 5, 10);         // timeout
    vecs[3]  = mk(100, 5, 1000, 0, 5, 0, 0, 0, 0, 1, 0, 0);      // no active
    vecs[4]  = mk(0, 32'h1234, 3, 7, 32'h1234, 0, 0, 1, 0, 0, 32'h1234, 7); // last wait cycle
    vecs[5]  = mk(0, 5, 4, 7, 5, 0, 0, 0, 0, 1, 0, 0);           // active one cycle late
    vecs[6]  = mk(20, 9, 1, 20, 9, 0, 0, 1, 0, 0, 9, 20);        // fall on limit cycle
    vecs[7]  = mk(19, 9, 1, 20, 9, 0, 0, 0, 1, 0, 9, 19);        // limit one short
    vecs[8]  = mk(1, 7, 1, 0, 7, 0, 0, 0, 1, 0, 7, 1);           // limit of one
    vecs[9]  = mk(100, 5, 1, 20, 5, 0, 1, 1, 0, 0, 5, 20);       // start while busy
    vecs[10] = mk(0, 2, 1, 10, 0, 1, 0, 1, 0, 0, 2, 10);         // v0 stepping

    repeat (3) @(negedge clk);
    check("rst_cpu_reset", bus.cpu_reset, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_clk_en", bus.cpu_clk_enable, 0);
    check("rst_count", bus.cycle_count, 0);
    check("rst_result", bus.result_v0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cpu_reset", bus.cpu_reset, 0);
    check("idle_busy", bus.busy, 0);
    $display("reset: cpu_reset released, idle");

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Abort in RUN cycle 5 with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.timeout_cycles = 100;
    bus.expected_v0 = 5;
    @(negedge clk);
    bus.start = 1'b0;
    en = 0;
    reached = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.busy && bus.cpu_clk_enable && bus.cycle_count == 4) begin
        reached = 1;
        break;
      end
      if (bus.cpu_reset) en = 0;
      else if (bus.cpu_clk_enable) en++;
      drive_cpu(en, 1, 0, 5, 0);
      @(negedge clk);
    end
    check("abort_reached_run5", reached, 1);
    rst_n = 1'b0;
    #1;
    check("abort_cpu_reset", bus.cpu_reset, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_clk_en", bus.cpu_clk_enable, 0);
    $display("abort: reset mid-run, cpu_reset=%0b busy=%0b done=%0b",
             bus.cpu_reset, bus.busy, bus.done);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("release_start_masked", bus.busy, 0);
    @(negedge clk);
    check("release_idle_busy", bus.busy, 0);
    check("release_cpu_reset", bus.cpu_reset, 0);
    $display("release: start on reset release ignored, busy=%0b", bus.busy);
    run_vec(11, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
